// File: rtl/cp0_timer_pkg.sv
// Shared register map and CTRL layout for the CP0 count/compare timer.
// Latency: n/a (constants and address helpers only).
// Backpressure: n/a.
package cp0_timer_pkg;

    // Register addresses. Channel i owns a COMPARE/PERIOD pair starting at the base.
    localparam logic [31:0] CNT_COUNT        = 32'd0;
    localparam logic [31:0] CNT_CTRL         = 32'd1;
    localparam logic [31:0] CNT_COMPARE_BASE = 32'd2;

    // CTRL bit positions; the per-channel fields are NUM_CMP wide starting here.
    localparam int CTRL_DC       = 0;
    localparam int CTRL_PER_LSB  = 8;
    localparam int CTRL_PEND_LSB = 16;
    localparam int CTRL_IE_LSB   = 24;

    // Reset image: channel 0 interrupt enabled, Count running, all one-shot.
    localparam logic [31:0] CTRL_RESET    = 32'h0100_0000;
    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    function automatic logic [31:0] cmp_addr(input int ch);
        return CNT_COMPARE_BASE + 32'(2 * ch);
    endfunction

    function automatic logic [31:0] prd_addr(input int ch);
        return CNT_COMPARE_BASE + 32'(2 * ch + 1);
    endfunction

endpackage

// File: rtl/cp0_timer_channel.sv
// One compare channel: compare/period registers, sticky pending flag, auto-reload.
// Latency: match seen on registered count/compare sets pend and reloads at the next edge.
// Backpressure: none; writes always accepted, a COMPARE write beats a same-cycle match.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   count           current Count value
//   periodic        PER bit for this channel
//   cmp_wen/prd_wen write strobes for COMPARE/PERIOD, data on wdata
//   compare/period  register values (for readback)
//   pend            sticky pending flag
module cp0_timer_channel
    import cp0_timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] count,
    input  logic        periodic,
    input  logic        cmp_wen,
    input  logic        prd_wen,
    input  logic [31:0] wdata,
    output logic [31:0] compare,
    output logic [31:0] period,
    output logic        pend
);

    logic match;

    assign match = (count == compare);

    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= COMPARE_RESET;
            period  <= '0;
            pend    <= 1'b0;
        end else begin
            // A software COMPARE write re-arms the channel and suppresses any
            // match that happens to coincide with it.
            if (cmp_wen) begin
                compare <= wdata;
                pend    <= 1'b0;
            end else if (match) begin
                pend <= 1'b1;
                // A zero period would re-match forever; treat it as one-shot.
                if (periodic && (period != 32'd0)) begin
                    compare <= compare + period;
                end
            end

            // Non-blocking update: a reload in this same cycle sees the old period.
            if (prd_wen) begin
                period <= wdata;
            end
        end
    end

endmodule

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with NUM_CMP channels, Count divider and ext_int synchroniser.
// Latency: writes land at the edge they are presented; pend/irq one edge after count==compare;
//          ip_hw follows ext_int SYNC_STAGES edges later. Backpressure: none.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wen/waddr/wdata   register write port
//   raddr/rdata       combinational register read port (unmapped -> 0)
//   ext_int           asynchronous external interrupt lines
//   ip_hw             Cause.IP[7:2]: synchronised ext_int, timer ORed into bit TI_IP-2
//   timer_irq         OR over channels of pending & enabled
//   count_out         current Count
module cp0_timer
    import cp0_timer_pkg::*;
#(
    parameter int NUM_CMP     = 1,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TI_IP       = 7,
    parameter int AW          = $clog2(2 + 2 * NUM_CMP)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic [5:0]    ext_int,
    output logic [5:0]    ip_hw,
    output logic          timer_irq,
    output logic [31:0]   count_out
);

    // With COUNT_DIV==1 the divider degenerates to a constant-zero single bit.
    localparam int            DW       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

    logic [DW-1:0]      div;
    logic [31:0]        count;
    logic               dc;
    logic [NUM_CMP-1:0] per;
    logic [NUM_CMP-1:0] ie;
    logic [NUM_CMP-1:0] pend;
    logic [31:0]        cmp_val [NUM_CMP];
    logic [31:0]        prd_val [NUM_CMP];
    logic [5:0]         sync_q  [SYNC_STAGES];
    logic               count_wen;
    logic               ctrl_wen;
    logic               tick;
    logic [31:0]        ctrl_rd;

    assign count_wen = wen && (32'(waddr) == CNT_COUNT);
    assign ctrl_wen  = wen && (32'(waddr) == CNT_CTRL);
    assign tick      = !dc && (div == DIV_LAST);

    // ------------------------------------------------------------------
    // Divider and Count. A COUNT write also restarts the divider so the
    // new value is held for a full COUNT_DIV period.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            div   <= '0;
            count <= '0;
        end else if (count_wen) begin
            div   <= '0;
            count <= wdata;
        end else if (tick) begin
            div   <= '0;
            count <= count + 32'd1;
        end else if (!dc) begin
            div <= div + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // CTRL: DC, PER and IE are writable; PEND is owned by the channels.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dc  <= CTRL_RESET[CTRL_DC];
            per <= CTRL_RESET[CTRL_PER_LSB +: NUM_CMP];
            ie  <= CTRL_RESET[CTRL_IE_LSB +: NUM_CMP];
        end else if (ctrl_wen) begin
            dc  <= wdata[CTRL_DC];
            per <= wdata[CTRL_PER_LSB +: NUM_CMP];
            ie  <= wdata[CTRL_IE_LSB +: NUM_CMP];
        end
    end

    always_comb begin
        ctrl_rd                              = '0;
        ctrl_rd[CTRL_DC]                     = dc;
        ctrl_rd[CTRL_PER_LSB +: NUM_CMP]     = per;
        ctrl_rd[CTRL_PEND_LSB +: NUM_CMP]    = pend;
        ctrl_rd[CTRL_IE_LSB +: NUM_CMP]      = ie;
    end

    // ------------------------------------------------------------------
    // Compare channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CMP; g++) begin : g_ch
        logic cmp_wen;
        logic prd_wen;

        assign cmp_wen = wen && (32'(waddr) == cmp_addr(g));
        assign prd_wen = wen && (32'(waddr) == prd_addr(g));

        cp0_timer_channel u_ch (
            .clk      (clk),
            .reset    (reset),
            .count    (count),
            .periodic (per[g]),
            .cmp_wen  (cmp_wen),
            .prd_wen  (prd_wen),
            .wdata    (wdata),
            .compare  (cmp_val[g]),
            .period   (prd_val[g]),
            .pend     (pend[g])
        );
    end

    // ------------------------------------------------------------------
    // External interrupt synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ext_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign timer_irq = |(pend & ie);
    assign count_out = count;

    always_comb begin
        ip_hw           = sync_q[SYNC_STAGES-1];
        ip_hw[TI_IP-2]  = sync_q[SYNC_STAGES-1][TI_IP-2] | timer_irq;
    end

    // Read mux: anything not matched below reads as zero.
    always_comb begin
        rdata = '0;
        if (32'(raddr) == CNT_COUNT) begin
            rdata = count;
        end else if (32'(raddr) == CNT_CTRL) begin
            rdata = ctrl_rd;
        end
        for (int i = 0; i < NUM_CMP; i++) begin
            if (32'(raddr) == cmp_addr(i)) begin
                rdata = cmp_val[i];
            end
            if (32'(raddr) == prd_addr(i)) begin
                rdata = prd_val[i];
            end
        end
    end

endmodule
